// File: rtl/config_regfile_pkg.sv
// config_regfile_pkg: register-map word indices and default ID shared by the register file
package config_regfile_pkg;
   localparam logic [31:0] ID_DEFAULT   = 32'hC0F1_0001;
   localparam int          W_ID         = 0;
   localparam int          W_SCRATCH    = 1;
   localparam int          W_IRQ_STATUS = 2;
   localparam int          W_IRQ_ENABLE = 3;
   localparam int          W_CTRL       = 4;
   localparam int          W_STAT       = 12;
endpackage

// File: rtl/config_regfile_if.sv
// config_regfile_if: read/write bus of the config register file
// master drives rd/raddr/wr/waddr/wdata/wstrb and receives rdata/rvalid; slave is the register file
interface config_regfile_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic                  rd;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  wr;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   modport master (output rd, raddr, wr, waddr, wdata, wstrb, input rdata, rvalid);
   modport slave  (input rd, raddr, wr, waddr, wdata, wstrb, output rdata, rvalid);
endinterface

// File: rtl/config_irq_ctrl.sv
// config_irq_ctrl: W1C interrupt status, interrupt enable and registered irq level
// ports: clk, rst_n, irq_src (event pulses), we_status/we_enable (decoded writes), wdata, bmask (per-bit lane mask), status, enable, irq
module config_irq_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] irq_src,
   input  logic                  we_status,
   input  logic                  we_enable,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] bmask,
   output logic [DATA_WIDTH-1:0] status,
   output logic [DATA_WIDTH-1:0] enable,
   output logic                  irq
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         status <= '0;
         enable <= '0;
         irq    <= 1'b0;
      end else begin
         // OR-ing the new events after the clear makes a same-cycle set win
         status <= (status & ~(we_status ? wdata & bmask : '0)) | irq_src;
         if (we_enable) enable <= (enable & ~bmask) | (wdata & bmask);
         irq <= |(status & enable);
      end
endmodule

// File: rtl/config_regfile.sv
// config_regfile: byte-strobed register file with ID, scratch, W1C interrupts, control and status words
// ports: clk, rst_n, bus (read/write port, 1-cycle read latency), ctrl/ctrl_wr (control values and write pulses), stat (status inputs), irq_src/irq
module config_regfile
   import config_regfile_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
   parameter int                    NUM_CTRL   = 4,
   parameter int                    NUM_STAT   = 4,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(ID_DEFAULT)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   config_regfile_if.slave                bus,
   output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl,
   output logic [NUM_CTRL-1:0]            ctrl_wr,
   input  logic [NUM_STAT*DATA_WIDTH-1:0] stat,
   input  logic [DATA_WIDTH-1:0]          irq_src,
   output logic                           irq
);
   localparam int LSB = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] A_ID  = ADDR_WIDTH'(W_ID);
   localparam logic [ADDR_WIDTH-1:0] A_SCR = ADDR_WIDTH'(W_SCRATCH);
   localparam logic [ADDR_WIDTH-1:0] A_IST = ADDR_WIDTH'(W_IRQ_STATUS);
   localparam logic [ADDR_WIDTH-1:0] A_IEN = ADDR_WIDTH'(W_IRQ_ENABLE);
   logic [ADDR_WIDTH-1:0]                ridx, widx;
   logic [DATA_WIDTH-1:0]                bmask, scratch, irq_status, irq_enable, rmux, rdata_q;
   logic [NUM_CTRL-1:0][DATA_WIDTH-1:0]  ctrl_q;
   logic [NUM_STAT-1:0][DATA_WIDTH-1:0]  stat_a;
   logic [NUM_CTRL-1:0]                  we_ctrl;
   logic                                 rvalid_q;
   assign ridx       = bus.raddr >> LSB;
   assign widx       = bus.waddr >> LSB;
   assign stat_a     = stat;
   assign ctrl       = ctrl_q;
   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_mask
      assign bmask[g] = bus.wstrb[g/8];
   end
   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old, wd, m);
      return (old & ~m) | (wd & m);
   endfunction
   always_comb begin
      we_ctrl = '0;
      for (int i = 0; i < NUM_CTRL; i++) we_ctrl[i] = bus.wr && widx == ADDR_WIDTH'(W_CTRL + i);
   end
   always_comb begin
      rmux = ridx == A_ID  ? ID_VALUE   :
             ridx == A_SCR ? scratch    :
             ridx == A_IST ? irq_status :
             ridx == A_IEN ? irq_enable : '0;
      for (int i = 0; i < NUM_CTRL; i++) if (ridx == ADDR_WIDTH'(W_CTRL + i)) rmux = ctrl_q[i];
      for (int i = 0; i < NUM_STAT; i++) if (ridx == ADDR_WIDTH'(W_STAT + i)) rmux = stat_a[i];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         scratch  <= '0;
         ctrl_q   <= '0;
         ctrl_wr  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= bus.rd;
         if (bus.rd) rdata_q <= rmux;
         if (bus.wr && widx == A_SCR) scratch <= merge(scratch, bus.wdata, bmask);
         ctrl_wr <= we_ctrl;
         for (int i = 0; i < NUM_CTRL; i++) if (we_ctrl[i]) ctrl_q[i] <= merge(ctrl_q[i], bus.wdata, bmask);
      end
   config_irq_ctrl #(.DATA_WIDTH(DATA_WIDTH)) u_irq (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_src   (irq_src),
      .we_status (bus.wr && widx == A_IST),
      .we_enable (bus.wr && widx == A_IEN),
      .wdata     (bus.wdata),
      .bmask     (bmask),
      .status    (irq_status),
      .enable    (irq_enable),
      .irq       (irq)
   );
endmodule

// File: tb/tb_config_regfile.sv
// tb_config_regfile: directed and random checks of config_regfile against a behavioural register-map model
module tb_config_regfile;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] ctrl;
   logic [3:0]   ctrl_wr;
   logic [127:0] stat;
   logic [31:0]  irq_src;
   logic         irq;
   int           errors = 0;
   int           checks = 0;
   logic [31:0]  m_scr, m_st, m_en, m_rdata;
   logic [31:0]  m_ctrl [4];
   logic [3:0]   m_cwr;
   logic         m_rv, m_irq;
   always #5 clk = ~clk;
   config_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus ();
   config_regfile dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .ctrl    (ctrl),
      .ctrl_wr (ctrl_wr),
      .stat    (stat),
      .irq_src (irq_src),
      .irq     (irq)
   );
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) old[b*8 +: 8] = wd[b*8 +: 8];
      return old;
   endfunction
   function automatic logic [31:0] mread(input logic [31:0] a);
      int unsigned w = a >> 2;
      if (w == 0) return 32'hC0F1_0001;
      if (w == 1) return m_scr;
      if (w == 2) return m_st;
      if (w == 3) return m_en;
      if (w >= 4 && w < 8) return m_ctrl[w-4];
      if (w >= 12 && w < 16) return stat[(w-12)*32 +: 32];
      return 32'h0;
   endfunction
   task automatic mreset();
      m_scr = 0; m_st = 0; m_en = 0; m_rdata = 0; m_cwr = 0; m_rv = 0; m_irq = 0;
      for (int i = 0; i < 4; i++) m_ctrl[i] = 0;
   endtask
   task automatic check_all(input string tag);
      chk({tag, ".rvalid"}, bus.rvalid, m_rv);
      chk({tag, ".rdata"}, bus.rdata, m_rdata);
      chk({tag, ".ctrl"}, ctrl, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
      chk({tag, ".ctrl_wr"}, ctrl_wr, m_cwr);
      chk({tag, ".irq"}, irq, m_irq);
   endtask
   // one clock: the model consumes the inputs as they stand, then outputs are compared after the edge
   task automatic cyc(input string tag);
      int unsigned w = bus.waddr >> 2;
      logic [31:0] wl = lanes(32'h0, bus.wdata, bus.wstrb);
      logic [31:0] rexp = mread(bus.raddr);
      m_irq = |(m_st & m_en);
      m_st = (m_st & ~((bus.wr && w == 2) ? wl : 32'h0)) | irq_src;
      if (bus.wr && w == 1) m_scr = lanes(m_scr, bus.wdata, bus.wstrb);
      if (bus.wr && w == 3) m_en = lanes(m_en, bus.wdata, bus.wstrb);
      m_cwr = 0;
      for (int i = 0; i < 4; i++)
         if (bus.wr && w == 4 + i) begin
            m_cwr[i] = 1'b1;
            m_ctrl[i] = lanes(m_ctrl[i], bus.wdata, bus.wstrb);
         end
      m_rv = bus.rd;
      if (bus.rd) m_rdata = rexp;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask
   task automatic idle();
      bus.rd = 0; bus.wr = 0; irq_src = 0;
   endtask
   task automatic do_wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.wr = 1; bus.waddr = a; bus.wdata = d; bus.wstrb = s;
      cyc(tag);
      idle();
   endtask
   task automatic do_rd(input string tag, input logic [31:0] a);
      bus.rd = 1; bus.raddr = a;
      cyc(tag);
      idle();
   endtask
   initial begin
      idle();
      bus.raddr = 0; bus.waddr = 0; bus.wdata = 0; bus.wstrb = 0;
      stat = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
      mreset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      do_rd("rd_id", 32'h0);
      chk("id_value", bus.rdata, 32'hC0F1_0001);
      do_rd("rd_scratch", 32'h4);
      chk("scratch_reset", bus.rdata, 32'h0);
      cyc("idle_hold");
      do_wr("scr_full", 32'h4, 32'h1122_3344, 4'hF);
      do_wr("scr_lanes", 32'h4, 32'hAABB_CCDD, 4'b0101);
      do_rd("rd_lanes", 32'h7);
      chk("byte_lanes", bus.rdata, 32'h11BB_33DD);
      do_wr("ctrl2", 32'd24, 32'h5, 4'hF);
      chk("ctrl2_val", ctrl[95:64], 32'h5);
      chk("ctrl2_pulse", ctrl_wr, 4'b0100);
      cyc("ctrl_pulse_end");
      do_wr("stat_ro", 32'd52, 32'hFFFF_FFFF, 4'hF);
      do_rd("rd_stat1", 32'd52);
      chk("stat1", bus.rdata, 32'h2222_0002);
      do_wr("ctrl0_nostrb", 32'd16, 32'hFFFF_FFFF, 4'h0);
      do_rd("rd_unmapped", 32'd40);
      chk("unmapped", bus.rdata, 32'h0);
      do_wr("irq_en", 32'd12, 32'h1, 4'hF);
      irq_src = 1;
      cyc("irq_pulse");
      idle();
      cyc("irq_rise");
      chk("irq_set", irq, 1'b1);
      bus.wr = 1; bus.waddr = 32'd8; bus.wdata = 32'h1; bus.wstrb = 4'hF; irq_src = 1;
      cyc("w1c_vs_set");
      idle();
      do_rd("rd_status", 32'd8);
      chk("set_wins", bus.rdata, 32'h1);
      do_wr("w1c", 32'd8, 32'h1, 4'hF);
      cyc("irq_fall");
      chk("irq_clear", irq, 1'b0);
      do_wr("scr7", 32'h4, 32'h7, 4'hF);
      bus.rd = 1; bus.raddr = 32'h4;
      bus.wr = 1; bus.waddr = 32'h4; bus.wdata = 32'h9; bus.wstrb = 4'hF;
      cyc("same_word");
      idle();
      chk("pre_write", bus.rdata, 32'h7);
      do_rd("post_write", 32'h4);
      chk("new_value", bus.rdata, 32'h9);
      for (int n = 0; n < 400; n++) begin
         bus.rd = 1'($urandom);
         bus.raddr = $urandom_range(0, 16) * 4 + $urandom_range(0, 3);
         bus.wr = 1'($urandom);
         bus.waddr = $urandom_range(0, 16) * 4 + $urandom_range(0, 3);
         bus.wdata = $urandom;
         bus.wstrb = 4'($urandom);
         irq_src = $urandom & $urandom & $urandom;
         stat = {$urandom, $urandom, $urandom, $urandom};
         cyc("random");
      end
      idle();
      do_wr("ctrl0_pre", 32'd16, 32'hDEAD_BEEF, 4'hF);
      bus.rd = 1; bus.raddr = 32'h0;
      #2;
      rst_n = 0;
      mreset();
      #1;
      check_all("abort");
      bus.wr = 1; bus.waddr = 32'd16; bus.wdata = 32'hFF; bus.wstrb = 4'hF;
      @(posedge clk);
      #1;
      check_all("in_reset");
      idle();
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      do_rd("rd_after", 32'h4);
      chk("scr_after", bus.rdata, 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
